rom_port_arbiter: RTL and testbench

Shares the single serial ROM controller port between the CPU instruction-fetch path (reads) and the serial ROM stream loader (writes). It issues one ROM transaction at a time using the ROM controller's request/busy handshake, returns read data to the CPU, and reports completion to each requester. In load mode the loader owns the port exclusively. In normal mode both requesters are arbitrated round-robin. A watchdog aborts requests the ROM never accepts.

---
 rtl/rom_port_pkg.sv | 20 ++
 rtl/rom_request_watchdog.sv | 39 +++
 rtl/rom_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_rom_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_pkg.sv
// Shared types and defaults for the ROM port arbiter and its watchdog.
package rom_port_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_ADDRESS_WIDTH  = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int WATCHDOG_WIDTH         = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        BUSY    = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_LD  = 1'b0,
        GRANT_CPU = 1'b1
    } grant_e;

endpackage

// File: rtl/rom_request_watchdog.sv
// Counts cycles a ROM request waits for acceptance; expired is high on the
// cycle whose closing edge brings the count to TIMEOUT_CYCLES.
module rom_request_watchdog
    import rom_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WATCHDOG_WIDTH-1:0] LAST_COUNT = WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WATCHDOG_WIDTH-1:0] count_q;
    logic [WATCHDOG_WIDTH-1:0] count_d;

    assign expired_o = enable_i && (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the serial ROM controller port between CPU reads and loader writes,
// one transaction at a time, with round-robin arbitration and a request watchdog.
module rom_port_arbiter
    import rom_port_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_mode,
    input  logic                     ld_request,
    input  logic [ADDRESS_WIDTH-1:0] ld_address,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_busy,
    output logic                     ld_done,
    input  logic                     cpu_request,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    output logic                     cpu_busy,
    output logic                     cpu_done,
    output logic [DATA_WIDTH-1:0]    cpu_data,
    input  logic                     rom_initialized,
    input  logic                     rom_busy,
    input  logic [DATA_WIDTH-1:0]    rom_rdata,
    output logic                     rom_request,
    output logic                     rom_write,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic [DATA_WIDTH-1:0]    rom_wdata,
    output logic                     timeout_error
);

    arb_state_e               state_q;
    grant_e                   owner_q;
    grant_e                   last_grant_q;
    logic                     rom_request_q;
    logic                     rom_write_q;
    logic                     ld_busy_q;
    logic                     ld_done_q;
    logic                     cpu_busy_q;
    logic                     cpu_done_q;
    logic                     timeout_error_q;
    logic [DATA_WIDTH-1:0]    cpu_data_q;
    logic [ADDRESS_WIDTH-1:0] rom_address_q;
    logic [DATA_WIDTH-1:0]    rom_wdata_q;

    logic   ld_eligible;
    logic   cpu_eligible;
    logic   can_grant;
    grant_e grant_pick;
    logic   wd_expired;

    assign ld_eligible  = ld_request;
    assign cpu_eligible = cpu_request && !load_mode;
    assign can_grant    = rom_initialized && !rom_busy && (ld_eligible || cpu_eligible);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_pick = GRANT_LD;
        if (ld_eligible && cpu_eligible) begin
            grant_pick = (last_grant_q == GRANT_LD) ? GRANT_CPU : GRANT_LD;
        end else if (cpu_eligible) begin
            grant_pick = GRANT_CPU;
        end
    end

    rom_request_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q == REQUEST),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= GRANT_LD;
            last_grant_q    <= GRANT_LD;
            rom_request_q   <= 1'b0;
            rom_write_q     <= 1'b0;
            ld_busy_q       <= 1'b0;
            ld_done_q       <= 1'b0;
            cpu_busy_q      <= 1'b0;
            cpu_done_q      <= 1'b0;
            timeout_error_q <= 1'b0;
            cpu_data_q      <= '0;
            rom_address_q   <= '0;
            rom_wdata_q     <= '0;
        end else begin
            ld_done_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (can_grant) begin
                        owner_q       <= grant_pick;
                        last_grant_q  <= grant_pick;
                        rom_request_q <= 1'b1;
                        state_q       <= REQUEST;
                        if (grant_pick == GRANT_LD) begin
                            rom_write_q   <= 1'b1;
                            rom_address_q <= ld_address;
                            rom_wdata_q   <= ld_data;
                            ld_busy_q     <= 1'b1;
                        end else begin
                            rom_write_q   <= 1'b0;
                            rom_address_q <= cpu_address;
                            cpu_busy_q    <= 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    // Acceptance wins over expiry on the same edge.
                    if (rom_busy) begin
                        rom_request_q <= 1'b0;
                        state_q       <= BUSY;
                    end else if (wd_expired) begin
                        rom_request_q   <= 1'b0;
                        ld_busy_q       <= 1'b0;
                        cpu_busy_q      <= 1'b0;
                        timeout_error_q <= 1'b1;
                        state_q         <= IDLE;
                    end
                end
                BUSY: begin
                    if (!rom_busy) begin
                        if (owner_q == GRANT_LD) begin
                            ld_busy_q <= 1'b0;
                            ld_done_q <= 1'b1;
                        end else begin
                            cpu_busy_q <= 1'b0;
                            cpu_done_q <= 1'b1;
                            cpu_data_q <= rom_rdata;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_request   = rom_request_q;
    assign rom_write     = rom_write_q;
    assign rom_address   = rom_address_q;
    assign rom_wdata     = rom_wdata_q;
    assign ld_busy       = ld_busy_q;
    assign ld_done       = ld_done_q;
    assign cpu_busy      = cpu_busy_q;
    assign cpu_done      = cpu_done_q;
    assign cpu_data      = cpu_data_q;
    assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed and randomized bench for rom_port_arbiter: a behavioural ROM
// responder, a transaction-level memory model and a round-robin grant model.
`timescale 1ns/1ps
module tb_rom_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_mode;
    logic          ld_request;
    logic [AW-1:0] ld_address;
    logic [DW-1:0] ld_data;
    logic          ld_busy;
    logic          ld_done;
    logic          cpu_request;
    logic [AW-1:0] cpu_address;
    logic          cpu_busy;
    logic          cpu_done;
    logic [DW-1:0] cpu_data;
    logic          rom_initialized;
    logic          rom_busy;
    logic [DW-1:0] rom_rdata;
    logic          rom_request;
    logic          rom_write;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] rom_wdata;
    logic          timeout_error;

    // ROM responder controls
    logic romAuto;
    logic romAccept;
    logic romBusyAuto;
    logic romBusyManual;
    int   acceptDelay;
    int   busyCycles;

    logic [DW-1:0] romMem [256];
    logic [DW-1:0] refMem [256];

    int checks;
    int errors;

    // Monitor statistics
    int   grantCount, cpuGrantCount, ldGrantCount;
    int   cpuDoneCount, ldDoneCount, pulseErr, overlapErr;
    int   reqRun, lastReqRun;
    bit   grantLog[$];
    logic prevReq, prevCpuDone, prevLdDone;

    assign rom_busy = romAuto ? romBusyAuto : romBusyManual;

    always #5 clk = ~clk;

    rom_port_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_mode      (load_mode),
        .ld_request     (ld_request),
        .ld_address     (ld_address),
        .ld_data        (ld_data),
        .ld_busy        (ld_busy),
        .ld_done        (ld_done),
        .cpu_request    (cpu_request),
        .cpu_address    (cpu_address),
        .cpu_busy       (cpu_busy),
        .cpu_done       (cpu_done),
        .cpu_data       (cpu_data),
        .rom_initialized(rom_initialized),
        .rom_busy       (rom_busy),
        .rom_rdata      (rom_rdata),
        .rom_request    (rom_request),
        .rom_write      (rom_write),
        .rom_address    (rom_address),
        .rom_wdata      (rom_wdata),
        .timeout_error  (timeout_error)
    );

    function automatic logic [DW-1:0] initWord(input int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 37) ^ 16'h5A3C;
    endfunction

    // ROM controller model: accepts after acceptDelay cycles, stays busy busyCycles.
    initial begin
        romBusyAuto = 1'b0;
        rom_rdata   = '0;
        for (int i = 0; i < 256; i++) romMem[i] = initWord(i);
        forever begin
            @(negedge clk);
            if (romAuto && romAccept && rom_request && !reset) begin
                repeat (acceptDelay) @(negedge clk);
                romBusyAuto = 1'b1;
                if (rom_write) romMem[rom_address[7:0]] = rom_wdata;
                else           rom_rdata = romMem[rom_address[7:0]];
                repeat (busyCycles) @(negedge clk);
                romBusyAuto = 1'b0;
            end
        end
    end

    // Passive monitor sampling shortly after each rising edge.
    initial begin
        grantCount = 0; cpuGrantCount = 0; ldGrantCount = 0;
        cpuDoneCount = 0; ldDoneCount = 0; pulseErr = 0; overlapErr = 0;
        reqRun = 0; lastReqRun = 0;
        prevReq = 1'b0; prevCpuDone = 1'b0; prevLdDone = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rom_request && !prevReq) begin
                grantCount++;
                grantLog.push_back(rom_write);
                if (rom_write) ldGrantCount++;
                else           cpuGrantCount++;
                reqRun = 0;
            end
            if (rom_request) reqRun++;
            if (!rom_request && prevReq) lastReqRun = reqRun;
            if (cpu_done) cpuDoneCount++;
            if (ld_done)  ldDoneCount++;
            if ((cpu_done && prevCpuDone) || (ld_done && prevLdDone)) pulseErr++;
            if (cpu_busy && ld_busy) overlapErr++;
            prevReq     = rom_request;
            prevCpuDone = cpu_done;
            prevLdDone  = ld_done;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One complete transaction from a single requester, called at a falling edge with the arbiter idle.
    task automatic applyStimulus(input bit isLoader, input logic [15:0] addr, input logic [15:0] data,
                                 input int accDelay, input int busyCyc);
        int cycles;
        bit seenDone;
        acceptDelay = accDelay;
        busyCycles  = busyCyc;
        if (isLoader) begin
            ld_address = addr; ld_data = data; ld_request = 1'b1;
        end else begin
            cpu_address = addr; cpu_request = 1'b1;
        end
        cycles   = 0;
        seenDone = 1'b0;
        while (!seenDone && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (isLoader && ld_busy)   ld_request  = 1'b0;
            if (!isLoader && cpu_busy) cpu_request = 1'b0;
            seenDone = isLoader ? ld_done : cpu_done;
        end
        ld_request  = 1'b0;
        cpu_request = 1'b0;
        if (isLoader) begin
            checkOutput("ld_done_seen", 32'(seenDone), 32'd1);
            checkOutput("ld_busy_at_done", 32'(ld_busy), 32'd0);
            refMem[addr[7:0]] = data;
            checkOutput("rom_written", 32'(romMem[addr[7:0]]), 32'(data));
        end else begin
            checkOutput("cpu_done_seen", 32'(seenDone), 32'd1);
            checkOutput("cpu_busy_at_done", 32'(cpu_busy), 32'd0);
            checkOutput("cpu_data", 32'(cpu_data), 32'(refMem[addr[7:0]]));
            checkOutput("cpu_latency", 32'(cycles), 32'(2 + accDelay + busyCyc));
        end
    endtask

    // Finish a CPU read whose request is already raised.
    task automatic awaitCpu(input string tag, input logic [15:0] addr);
        bit seenDone;
        seenDone = 1'b0;
        for (int n = 0; n < 100 && !seenDone; n++) begin
            if (cpu_busy) cpu_request = 1'b0;
            if (cpu_done) seenDone = 1'b1;
            else @(negedge clk);
        end
        cpu_request = 1'b0;
        checkOutput({tag, "_done"}, 32'(seenDone), 32'd1);
        checkOutput({tag, "_data"}, 32'(cpu_data), 32'(refMem[addr[7:0]]));
    endtask

    initial begin
        int   base;
        int   ldBase;
        int   cpuBase;
        int   n;
        bit   lastWasLd;
        bit   expLd;
        logic [15:0] rrData;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);

        // Reset with the ROM not yet initialised and the CPU already asking.
        reset = 1'b1; rom_initialized = 1'b0; load_mode = 1'b0;
        ld_request = 1'b0; ld_address = '0; ld_data = '0;
        cpu_request = 1'b1; cpu_address = 16'h0100;
        romAuto = 1'b1; romAccept = 1'b1; romBusyManual = 1'b0;
        acceptDelay = 0; busyCycles = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_rom_request", 32'(rom_request), 32'd0);
        checkOutput("rst_rom_write", 32'(rom_write), 32'd0);
        checkOutput("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        checkOutput("rst_ld_busy", 32'(ld_busy), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_error), 32'd0);
        checkOutput("rst_cpu_data", 32'(cpu_data), 32'd0);
        checkOutput("rst_rom_address", 32'(rom_address), 32'd0);
        checkOutput("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("no_grant_uninit", 32'(rom_request), 32'd0);
        rom_initialized = 1'b1;
        @(negedge clk);
        checkOutput("init_rom_request", 32'(rom_request), 32'd1);
        checkOutput("init_rom_write", 32'(rom_write), 32'd0);
        checkOutput("init_rom_address", 32'(rom_address), 32'h0100);
        checkOutput("init_cpu_busy", 32'(cpu_busy), 32'd1);
        awaitCpu("init_read", 16'h0100);
        @(negedge clk);

        // Known-value read and the latest-possible acceptance.
        applyStimulus(1'b0, 16'h0010, 16'h0000, 0, 3);
        checkOutput("cpu_data_beef", 32'(cpu_data), 32'h0000BEEF);
        applyStimulus(1'b0, 16'h0022, 16'h0000, TO - 1, 2);
        checkOutput("late_accept_no_timeout", 32'(timeout_error), 32'd0);

        // Load mode: loader owns the port while the CPU keeps asking.
        load_mode = 1'b1;
        cpu_address = 16'h0040;
        cpu_request = 1'b1;
        ldBase  = ldDoneCount;
        cpuBase = cpuGrantCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(i), 16'h1234, $urandom_range(0, 2), $urandom_range(1, 3));
            cpu_request = 1'b1;
        end
        checkOutput("load_ld_done_count", 32'(ldDoneCount - ldBase), 32'd8);
        checkOutput("load_cpu_grants", 32'(cpuGrantCount - cpuBase), 32'd0);
        acceptDelay = 1; busyCycles = 2;
        load_mode = 1'b0;
        @(negedge clk);
        awaitCpu("after_load", 16'h0040);
        checkOutput("after_load_cpu_grants", 32'(cpuGrantCount - cpuBase), 32'd1);
        @(negedge clk);

        // Randomized single transactions against the memory model.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom),
                          $urandom_range(0, TO - 1), $urandom_range(1, 4));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'(i), 16'h0000, $urandom_range(0, 1), 1);
            checkOutput("loaded_word_readback", 32'(cpu_data), 32'h1234);
        end

        // No grant while the ROM reports busy in IDLE.
        romAuto = 1'b0; romBusyManual = 1'b1;
        cpu_address = 16'h0055; cpu_request = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("no_grant_rom_busy", 32'(rom_request), 32'd0);
        romBusyManual = 1'b0; romAuto = 1'b1;
        acceptDelay = 0; busyCycles = 1;
        @(negedge clk);
        checkOutput("grant_after_rom_idle", 32'(rom_request), 32'd1);
        awaitCpu("busy_gate_read", 16'h0055);
        @(negedge clk);

        // Watchdog abort: the ROM never accepts.
        romAccept = 1'b0;
        cpuBase = cpuDoneCount;
        cpu_address = 16'h0066; cpu_request = 1'b1;
        n = 0;
        while (!cpu_busy && n < 10) begin @(negedge clk); n++; end
        cpu_request = 1'b0;
        n = 0;
        while (cpu_busy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        checkOutput("timeout_busy_dropped", 32'(cpu_busy), 32'd0);
        checkOutput("timeout_request_cycles", 32'(lastReqRun), 32'(TO));
        checkOutput("timeout_error_set", 32'(timeout_error), 32'd1);
        checkOutput("timeout_no_done", 32'(cpuDoneCount - cpuBase), 32'd0);
        romAccept = 1'b1;
        applyStimulus(1'b1, 16'h0077, 16'($urandom), 0, 1);
        checkOutput("timeout_error_sticky", 32'(timeout_error), 32'd1);

        // Reset while a loader write sits in BUSY.
        romAuto = 1'b0; romBusyManual = 1'b0;
        ld_address = 16'h0088; ld_data = 16'hA5A5; ld_request = 1'b1;
        n = 0;
        while (!rom_request && n < 10) begin @(negedge clk); n++; end
        ld_request = 1'b0;
        romBusyManual = 1'b1;
        @(negedge clk);
        checkOutput("pre_reset_in_busy", 32'({rom_request, ld_busy, rom_write}), 32'b011);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    32'({rom_request, rom_write, ld_busy, ld_done, cpu_busy, cpu_done, timeout_error}), 32'd0);
        checkOutput("async_reset_cpu_data", 32'(cpu_data), 32'd0);
        checkOutput("async_reset_rom_address", 32'(rom_address), 32'd0);
        checkOutput("async_reset_rom_wdata", 32'(rom_wdata), 32'd0);
        romBusyManual = 1'b0; romAuto = 1'b1;
        acceptDelay = 0; busyCycles = 1;

        // Both requesting continuously after reset: grants alternate, CPU first.
        rrData = 16'($urandom);
        cpu_address = 16'h0020; ld_address = 16'h0030; ld_data = rrData;
        cpu_request = 1'b1; ld_request = 1'b1;
        base = grantCount;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while ((grantCount - base) < 4 && n < 200) begin @(negedge clk); n++; end
        cpu_request = 1'b0; ld_request = 1'b0;
        n = 0;
        while ((cpu_busy || ld_busy) && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        checkOutput("rr_grant_total", 32'(grantCount - base), 32'd4);
        lastWasLd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expLd = !lastWasLd;
            checkOutput($sformatf("rr_grant_%0d_is_ld", k),
                        ((base + k) < grantLog.size()) ? 32'(grantLog[base + k]) : 32'd2, 32'(expLd));
            lastWasLd = expLd;
        end
        refMem[8'h30] = rrData;
        checkOutput("rr_cpu_data", 32'(cpu_data), 32'(refMem[8'h20]));
        checkOutput("rr_ld_written", 32'(romMem[8'h30]), 32'(rrData));

        checkOutput("done_pulse_width", 32'(pulseErr), 32'd0);
        checkOutput("busy_exclusive", 32'(overlapErr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
